i2c_master_arbiter: RTL and testbench
=====================================

Name: i2c_master_arbiter

Overview:
- Shares one i2c_master instance among NUM_REQ independent requesters, e.g. a slow-control register block, a sensor-polling sequencer and a debug port.
- Arbitrates round-robin and latches the winner's transaction fields onto the master's input bus.
- Launches the transaction with a clean START rising edge and tracks BUSY to completion.
- Returns the received data and a per-requester DONE/ERR pulse.
- Sits between the requesters and i2c_master; it does not touch SDA or SCL.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- START_TIMEOUT, 15: CLK cycles to wait for M_BUSY after raising M_START before declaring an error (1..255).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset.
- REQ  in  NUM_REQ  per-requester request level. Must be held until the matching GNT bit is seen.
- REQ_SL_ADDR  in  7*NUM_REQ  slave address; requester i uses bits [7i+6:7i].
- REQ_DATA  in  56*NUM_REQ  bytes to transmit; requester i uses bits [56i+55:56i].
- REQ_NTX  in  3*NUM_REQ  number of bytes to transmit.
- REQ_NRX  in  5*NUM_REQ  number of bytes to receive.
- REQ_REP_START  in  NUM_REQ  repeated-start flag.
- GNT  out  NUM_REQ  one-hot grant; held for the whole transaction.
- DONE  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- ERR  out  1  qualifies DONE; high in the same cycle as DONE if the start timed out.
- RX_DATA  out  248  data received by the last completed transaction; valid from the DONE cycle until the next DONE.
- M_START  out  1  to master START.
- M_BUSY  in  1  from master BUSY.
- M_SL_ADDR  out  7  to master.
- M_DATA  out  56  to master.
- M_NTX  out  3  to master.
- M_NRX  out  5  to master.
- M_REP_START  out  1  to master.
- M_DATA_REC  in  248  from master I2C_DATA_REC.

Behaviour:
- Interface: reset RST_N, asynchronous, active-low; clock CLK.
- All outputs are registered.
- Reset values:
  - GNT, DONE, ERR, M_START, M_REP_START = 0.
  - RX_DATA, M_SL_ADDR, M_DATA, M_NTX, M_NRX = 0.
  - last_grant = NUM_REQ-1, so requester 0 has top priority after reset.
  - Reset mid-transaction aborts arbiter state only. The master finishes on its own, and the arbiter waits in IDLE for M_BUSY=0.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, RUN, FINISH.
- IDLE:
  - Arbitrates only when |REQ and M_BUSY=0; REQ is ignored in all other states.
  - Winner is the first set REQ bit scanning upward from last_grant+1, wrapping modulo NUM_REQ.
  - On the next edge: set GNT[w], latch w's fields into the M_* registers, go to LAUNCH.
- LAUNCH: set M_START=1, clear the timeout counter, go to WAIT_BUSY.
  - M_START is therefore first high one cycle after GNT and two cycles after REQ is sampled.
  - M_START is always low in IDLE, which guarantees the rising edge the master's edge detector requires.
- WAIT_BUSY:
  - If M_BUSY=1: M_START<=0, go to RUN.
  - Else increment the counter. When the counter reaches START_TIMEOUT:
    - set M_START<=0, DONE[w]<=1, ERR<=1;
    - clear GNT, set last_grant<=w, go to IDLE;
    - leave RX_DATA unchanged.
- RUN: when M_BUSY=0, go to FINISH. There is no limit on transaction duration.
- FINISH (one cycle):
  - RX_DATA<=M_DATA_REC, DONE[w]<=1, ERR<=0.
  - GNT<=0, last_grant<=w, go to IDLE.
- DONE and ERR are high for exactly one cycle.
- M_* field registers hold their value after completion; they change only on a new grant.
- REQ dropped after GNT: the transaction still completes and DONE is still pulsed; there is no abort path.
- REQ held high through DONE: re-arbitrated in the next IDLE cycle, with the round-robin pointer already moved past it.
- Minimum gap between DONE and the next GNT is one cycle.

Test Plan:
- Single request: REQ=0001, SL_ADDR=0x50, NTX=2, NRX=4; bench master raises BUSY 2 cycles after START and holds it 100 cycles.
  - Expect GNT=0001 one cycle after REQ is sampled and M_START one cycle later.
  - Expect M_START to fall the cycle after BUSY rises.
  - Expect DONE=0001 with ERR=0 and RX_DATA equal to the driven M_DATA_REC pattern.
- Simultaneous REQ=1111 held until each requester's DONE: grants in order 0,1,2,3; no overlapping GNT bits; M_START low for at least 1 cycle between transactions.
- Fairness: complete a grant to requester 2, then drive REQ=1001. Requester 3 is granted before requester 0.
- Timeout: M_BUSY never rises. After START_TIMEOUT=15 cycles in WAIT_BUSY: M_START=0, DONE pulses with ERR=1, RX_DATA is unchanged, GNT clears.
- External busy: M_BUSY=1 while in IDLE with REQ=0100. No GNT until M_BUSY=0, then GNT=0100 on the next edge.
- Reset mid-RUN: assert RST_N low during RUN with the master still busy.
  - All outputs return to reset values asynchronously.
  - After release with REQ=0010 pending, GNT stays 0 until M_BUSY=0, then requester 1 is granted.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares a single i2c_master among NUM_REQ requesters.
// It latches the winner's transaction fields, launches START, and reports DONE/ERR with the received data.
module i2c_master_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [7*NUM_REQ-1:0]   REQ_SL_ADDR,
  input  logic [56*NUM_REQ-1:0]  REQ_DATA,
  input  logic [3*NUM_REQ-1:0]   REQ_NTX,
  input  logic [5*NUM_REQ-1:0]   REQ_NRX,
  input  logic [NUM_REQ-1:0]     REQ_REP_START,
  output logic [NUM_REQ-1:0]     GNT,
  output logic [NUM_REQ-1:0]     DONE,
  output logic                   ERR,
  output logic [247:0]           RX_DATA,
  output logic                   M_START,
  input  logic                   M_BUSY,
  output logic [6:0]             M_SL_ADDR,
  output logic [55:0]            M_DATA,
  output logic [2:0]             M_NTX,
  output logic [4:0]             M_NRX,
  output logic                   M_REP_START,
  input  logic [247:0]           M_DATA_REC
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TO_LAST = 8'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_RUN       = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

  state_t             state_r;
  logic [IW-1:0]      last_grant_r;
  logic [IW-1:0]      cur_r;
  logic [7:0]         cnt_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [NUM_REQ-1:0] done_r;
  logic               err_r;
  logic [247:0]       rx_data_r;
  logic               m_start_r;
  logic [6:0]         m_sl_addr_r;
  logic [55:0]        m_data_r;
  logic [2:0]         m_ntx_r;
  logic [4:0]         m_nrx_r;
  logic               m_rep_start_r;

  logic [IW-1:0]      winner_s;
  logic               req_any_s;

  function automatic logic [NUM_REQ-1:0] onehot_f(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first set REQ bit above last_grant_r, wrapping.
  always_comb begin
    int unsigned idx_v;
    logic        found_v;
    winner_s  = last_grant_r;
    found_v   = 1'b0;
    req_any_s = |REQ;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_v = (int'(last_grant_r) + k) % NUM_REQ;
      if (!found_v && REQ[idx_v]) begin
        winner_s = IW'(idx_v);
        found_v  = 1'b1;
      end else begin
        found_v  = found_v;
      end
    end
  end

  // Arbitration / launch / completion FSM with all outputs registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r       <= ST_IDLE;
      last_grant_r  <= IW'(NUM_REQ - 1);
      cur_r         <= '0;
      cnt_r         <= 8'd0;
      gnt_r         <= '0;
      done_r        <= '0;
      err_r         <= 1'b0;
      rx_data_r     <= '0;
      m_start_r     <= 1'b0;
      m_sl_addr_r   <= 7'd0;
      m_data_r      <= 56'd0;
      m_ntx_r       <= 3'd0;
      m_nrx_r       <= 5'd0;
      m_rep_start_r <= 1'b0;
    end else begin
      done_r <= '0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          m_start_r <= 1'b0;
          // A reset mid-transaction lands here with the master still busy; wait it out.
          if (req_any_s && !M_BUSY) begin
            cur_r         <= winner_s;
            gnt_r         <= onehot_f(winner_s);
            m_sl_addr_r   <= REQ_SL_ADDR[int'(winner_s) * 7 +: 7];
            m_data_r      <= REQ_DATA[int'(winner_s) * 56 +: 56];
            m_ntx_r       <= REQ_NTX[int'(winner_s) * 3 +: 3];
            m_nrx_r       <= REQ_NRX[int'(winner_s) * 5 +: 5];
            m_rep_start_r <= REQ_REP_START[winner_s];
            state_r       <= ST_LAUNCH;
          end else begin
            state_r       <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          m_start_r <= 1'b1;
          cnt_r     <= 8'd0;
          state_r   <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (M_BUSY) begin
            m_start_r <= 1'b0;
            state_r   <= ST_RUN;
          end else if (cnt_r == TO_LAST) begin
            m_start_r    <= 1'b0;
            done_r       <= onehot_f(cur_r);
            err_r        <= 1'b1;
            gnt_r        <= '0;
            last_grant_r <= cur_r;
            state_r      <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_RUN: begin
          if (!M_BUSY) begin
            state_r <= ST_FINISH;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FINISH: begin
          rx_data_r    <= M_DATA_REC;
          done_r       <= onehot_f(cur_r);
          err_r        <= 1'b0;
          gnt_r        <= '0;
          last_grant_r <= cur_r;
          state_r      <= ST_IDLE;
        end
        default: begin
          m_start_r <= 1'b0;
          gnt_r     <= '0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign GNT         = gnt_r;
  assign DONE        = done_r;
  assign ERR         = err_r;
  assign RX_DATA     = rx_data_r;
  assign M_START     = m_start_r;
  assign M_SL_ADDR   = m_sl_addr_r;
  assign M_DATA      = m_data_r;
  assign M_NTX       = m_ntx_r;
  assign M_NRX       = m_nrx_r;
  assign M_REP_START = m_rep_start_r;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: a scripted master model drives M_BUSY/M_DATA_REC
// and every expectation is hand-derived from the arbitration and launch timing.
module tb_i2c_master_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int START_TIMEOUT = 15;

  logic                   CLK;
  logic                   RST_N;
  logic [NUM_REQ-1:0]     REQ;
  logic [7*NUM_REQ-1:0]   REQ_SL_ADDR;
  logic [56*NUM_REQ-1:0]  REQ_DATA;
  logic [3*NUM_REQ-1:0]   REQ_NTX;
  logic [5*NUM_REQ-1:0]   REQ_NRX;
  logic [NUM_REQ-1:0]     REQ_REP_START;
  logic [NUM_REQ-1:0]     GNT;
  logic [NUM_REQ-1:0]     DONE;
  logic                   ERR;
  logic [247:0]           RX_DATA;
  logic                   M_START;
  logic                   M_BUSY;
  logic [6:0]             M_SL_ADDR;
  logic [55:0]            M_DATA;
  logic [2:0]             M_NTX;
  logic [4:0]             M_NRX;
  logic                   M_REP_START;
  logic [247:0]           M_DATA_REC;

  int n_vec  = 0;
  int n_miss = 0;
  logic [247:0] last_rx;

  i2c_master_arbiter #(.NUM_REQ(NUM_REQ), .START_TIMEOUT(START_TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_SL_ADDR(REQ_SL_ADDR), .REQ_DATA(REQ_DATA),
    .REQ_NTX(REQ_NTX), .REQ_NRX(REQ_NRX), .REQ_REP_START(REQ_REP_START), .GNT(GNT),
    .DONE(DONE), .ERR(ERR), .RX_DATA(RX_DATA), .M_START(M_START), .M_BUSY(M_BUSY),
    .M_SL_ADDR(M_SL_ADDR), .M_DATA(M_DATA), .M_NTX(M_NTX), .M_NRX(M_NRX),
    .M_REP_START(M_REP_START), .M_DATA_REC(M_DATA_REC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
  endtask

  // One transaction from START to DONE; busy_en=0 lets the start time out.
  task automatic txn(input logic [3:0] g, input bit busy_en, input int len,
                     input logic [247:0] rec, input bit exp_err, input logic [247:0] exp_rx);
    int n;
    int hi;
    int idx;
    logic [7:0] b;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) if (g[k]) idx = k;
    b = 8'h10 + 8'(idx);
    n = 0;
    while (M_START !== 1'b1 && n < 20) begin tick(); n++; end
    check_val("start_seen", M_START, 1);
    check_val("gnt", GNT, g);
    check_val("sl_addr", M_SL_ADDR, 7'h50 + 7'(idx));
    check_val("m_data", M_DATA, {7{b}});
    check_val("m_nrx", M_NRX, 5'd4 + 5'(idx));
    check_val("m_ntx", M_NTX, 3'd2);
    M_DATA_REC = rec;
    if (busy_en) begin
      tick(); tick();
      M_BUSY = 1'b1;
      tick();
      check_val("start_fall", M_START, 0);
      repeat (len - 1) tick();
      M_BUSY = 1'b0;
    end
    hi = 0;
    n = 0;
    while (DONE === '0 && n < 40) begin
      if (M_START === 1'b1) hi++;
      tick();
      n++;
    end
    if (!busy_en) check_val("start_hi_cycles", hi, START_TIMEOUT);
    check_val("done", DONE, g);
    check_val("err", ERR, exp_err);
    check_val("gnt_clr", GNT, 0);
    check_val("rx_data", RX_DATA, exp_rx);
    check_val("start_lo", M_START, 0);
    REQ = REQ & ~g;
    tick();
    check_val("done_1cyc", {ERR, DONE}, 0);
    check_val("start_gap", M_START, 0);
  endtask

  function automatic logic [247:0] pat(input logic [7:0] s);
    return {31{s}};
  endfunction

  initial begin
    logic [7:0] b;
    RST_N = 1'b0;
    REQ = '0;
    M_BUSY = 1'b0;
    M_DATA_REC = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      b = 8'h10 + 8'(i);
      REQ_SL_ADDR[7*i +: 7] = 7'h50 + 7'(i);
      REQ_DATA[56*i +: 56]  = {7{b}};
      REQ_NTX[3*i +: 3]     = 3'd2;
      REQ_NRX[5*i +: 5]     = 5'd4 + 5'(i);
      REQ_REP_START[i]      = i[0];
    end
    repeat (2) tick();
    check_val("rst_gnt", GNT, 0);
    check_val("rst_done_err", {ERR, DONE}, 0);
    check_val("rst_start", {M_START, M_REP_START}, 0);
    check_val("rst_rx", RX_DATA, 0);
    check_val("rst_fields", {M_SL_ADDR, M_DATA, M_NTX, M_NRX}, 0);
    RST_N = 1'b1;

    // Single request
    REQ = 4'b0001;
    tick();
    check_val("t1_gnt", GNT, 4'b0001);
    check_val("t1_start_lo", M_START, 0);
    tick();
    check_val("t1_start_hi", M_START, 1);
    txn(4'b0001, 1'b1, 100, pat(8'hA5), 1'b0, pat(8'hA5));

    // All four together, pointer fresh from reset
    do_reset();
    REQ = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++)
      txn(4'(1 << i), 1'b1, 5, pat(8'h30 + 8'(i)), 1'b0, pat(8'h30 + 8'(i)));

    // Fairness after a grant to requester 2
    REQ = 4'b0100;
    txn(4'b0100, 1'b1, 4, pat(8'h42), 1'b0, pat(8'h42));
    REQ = 4'b1001;
    txn(4'b1000, 1'b1, 4, pat(8'h43), 1'b0, pat(8'h43));
    txn(4'b0001, 1'b1, 4, pat(8'h44), 1'b0, pat(8'h44));
    last_rx = pat(8'h44);

    // Start timeout: RX_DATA must keep the previous transaction's data
    REQ = 4'b0010;
    txn(4'b0010, 1'b0, 0, pat(8'hEE), 1'b1, last_rx);
    check_val("rep_start_kept", M_REP_START, 1);

    // External busy blocks arbitration
    M_BUSY = 1'b1;
    REQ = 4'b0100;
    repeat (3) tick();
    check_val("t5_no_gnt", GNT, 0);
    M_BUSY = 1'b0;
    tick();
    check_val("t5_gnt", GNT, 4'b0100);
    txn(4'b0100, 1'b1, 3, pat(8'h55), 1'b0, pat(8'h55));

    // Reset during RUN while the master stays busy
    REQ = 4'b0001;
    tick(); tick();
    check_val("t6_start", M_START, 1);
    tick(); tick();
    M_BUSY = 1'b1;
    repeat (3) tick();
    REQ = 4'b0000;
    #2 RST_N = 1'b0;
    #1;
    check_val("t6_async_gnt", GNT, 0);
    check_val("t6_async_rx", RX_DATA, 0);
    check_val("t6_async_fields", {M_START, M_SL_ADDR, M_DATA, M_NTX, M_NRX, M_REP_START}, 0);
    REQ = 4'b0010;
    tick();
    RST_N = 1'b1;
    repeat (3) tick();
    check_val("t6_wait_busy", GNT, 0);
    M_BUSY = 1'b0;
    tick();
    check_val("t6_gnt", GNT, 4'b0010);
    txn(4'b0010, 1'b1, 3, pat(8'h66), 1'b0, pat(8'h66));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
